// File: rtl/rr_arbiter8.sv
// rr_arbiter8: eight-requester round-robin arbiter with registered one-hot grant and hold-limit revocation
module rr_arbiter8 #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       En,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       gnt_v,
    output logic       timeout
);
    localparam int CW = $clog2(MAX_HOLD);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state, state_n;
    logic [2:0]    ptr, ptr_n, id_n, k;
    logic [CW-1:0] hold_cnt, cnt_n;
    logic [7:0]    gnt_n;
    logic          v_n, to_n, hit, rel;

    always_comb begin
        hit = 1'b0;
        k = ptr;
        for (int j = 7; j >= 0; j--)
            if (req[ptr - 3'(j)]) begin
                hit = 1'b1;
                k = ptr - 3'(j);
            end
        rel = !En || done || !req[gnt_id] || hold_cnt == CW'(MAX_HOLD - 1);
        state_n = state;
        ptr_n = ptr;
        cnt_n = hold_cnt;
        id_n = gnt_id;
        v_n = gnt_v;
        to_n = 1'b0;
        if (state == IDLE) begin
            if (En && hit) begin
                state_n = GRANT;
                id_n = k;
                v_n = 1'b1;
                cnt_n = '0;
                ptr_n = k - 3'd1;
            end
        end else if (rel) begin
            state_n = IDLE;
            id_n = 3'd0;
            v_n = 1'b0;
            to_n = En && !done && req[gnt_id];
        end else begin
            cnt_n = hold_cnt + CW'(1);
        end
        gnt_n = v_n ? 8'd1 << id_n : 8'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr <= 3'd7;
            hold_cnt <= '0;
            gnt <= 8'd0;
            gnt_id <= 3'd0;
            gnt_v <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state <= state_n;
            ptr <= ptr_n;
            hold_cnt <= cnt_n;
            gnt <= gnt_n;
            gnt_id <= id_n;
            gnt_v <= v_n;
            timeout <= to_n;
        end
    end
endmodule

// File: tb/tb_rr_arbiter8.sv
// tb_rr_arbiter8: directed scoreboard bench for rr_arbiter8 with MAX_HOLD=4
module tb_rr_arbiter8;
    logic       clk = 1'b0;
    logic       rst, En, done;
    logic [7:0] req, gnt;
    logic [2:0] gnt_id;
    logic       gnt_v, timeout;
    int         n_assert = 0;
    int         n_fail = 0;
    logic [12:0] sb[$];

    rr_arbiter8 #(.MAX_HOLD(4)) dut (
        .clk(clk), .rst(rst), .En(En), .req(req), .done(done),
        .gnt(gnt), .gnt_id(gnt_id), .gnt_v(gnt_v), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic cyc(input string tag, input logic r, input logic e, input logic [7:0] rq,
                       input logic d, input logic v, input logic [2:0] id, input logic to);
        logic [12:0] exp, obs;
        logic [7:0]  eg;
        @(negedge clk);
        rst = r;
        En = e;
        req = rq;
        done = d;
        eg = v ? 8'd1 << id : 8'd0;
        sb.push_back({v, v ? id : 3'd0, eg, to});
        @(posedge clk);
        #1;
        exp = sb.pop_front();
        obs = {gnt_v, gnt_id, gnt, timeout};
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed v/id/gnt/to=%b/%0d/%b/%b required %b/%0d/%b/%b", tag,
                   obs[12], obs[11:9], obs[8:1], obs[0], exp[12], exp[11:9], exp[8:1], exp[0]);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc("reset0", 1, 0, 8'h00, 0, 0, 0, 0);
        cyc("reset1", 1, 1, 8'h81, 0, 0, 0, 0);
        cyc("first_grant7", 0, 1, 8'h81, 0, 1, 7, 0);
        cyc("release7", 0, 1, 8'h81, 1, 0, 0, 0);
        cyc("grant0", 0, 1, 8'h81, 0, 1, 0, 0);
        cyc("release0", 0, 1, 8'h81, 1, 0, 0, 0);
        for (int i = 0; i < 9; i++) begin
            cyc("rr_grant", 0, 1, 8'hFF, 0, 1, 3'(7 - i), 0);
            cyc("rr_gap", 0, 1, 8'hFF, 1, 0, 0, 0);
        end
        cyc("drop_grant3", 0, 1, 8'h08, 0, 1, 3, 0);
        cyc("drop_release", 0, 1, 8'h00, 0, 0, 0, 0);
        cyc("ptr2_grant2", 0, 1, 8'h14, 0, 1, 2, 0);
        cyc("release2", 0, 1, 8'h14, 1, 0, 0, 0);
        cyc("hold_c0", 0, 1, 8'h40, 0, 1, 6, 0);
        cyc("hold_c1", 0, 1, 8'h40, 0, 1, 6, 0);
        cyc("hold_c2", 0, 1, 8'h40, 0, 1, 6, 0);
        cyc("hold_c3", 0, 1, 8'h40, 0, 1, 6, 0);
        cyc("timeout_pulse", 0, 1, 8'h40, 0, 0, 0, 1);
        cyc("regrant6", 0, 1, 8'h40, 0, 1, 6, 0);
        cyc("hold_d1", 0, 1, 8'h40, 0, 1, 6, 0);
        cyc("hold_d2", 0, 1, 8'h40, 0, 1, 6, 0);
        cyc("hold_d3", 0, 1, 8'h40, 0, 1, 6, 0);
        cyc("done_wins", 0, 1, 8'h40, 1, 0, 0, 0);
        cyc("no_timeout", 0, 1, 8'h00, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc("en_low", 0, 0, 8'hFF, 0, 0, 0, 0);
        cyc("en_grant5", 0, 1, 8'hFF, 0, 1, 5, 0);
        cyc("en_hold5", 0, 1, 8'hFF, 0, 1, 5, 0);
        cyc("en_drop", 0, 0, 8'hFF, 0, 0, 0, 0);
        cyc("req_zero0", 0, 1, 8'h00, 0, 0, 0, 0);
        cyc("req_zero1", 0, 1, 8'h00, 1, 0, 0, 0);
        cyc("grant2", 0, 1, 8'h04, 0, 1, 2, 0);
        cyc("hold2", 0, 1, 8'h04, 0, 1, 2, 0);
        cyc("mid_reset", 1, 1, 8'h04, 0, 0, 0, 0);
        cyc("ptr_restored7", 0, 1, 8'h84, 0, 1, 7, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
